accel_stream_feeder: RTL and testbench

//  Host-side driver for the CNN accelerator byte interface (mode/din/ram_en in; dout/out_data_flag out).

---
 rtl/accel_stream_feeder.sv | 225 ++++++++++++++++++++++
 tb/tb_accel_stream_feeder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_stream_feeder.sv
// ---------------------------------------------------------------------------
// accel_stream_feeder
//
// Host-side feeder for the CNN accelerator byte-load interface. Takes a
// valid/ready byte stream from the host and, for each frame, forwards
// N_WEIGHT weight bytes (mode=1) followed by N_DATA pixel bytes (mode=0)
// onto the accelerator load bus. It then waits for the accelerator result
// flag, captures the result byte and presents it to the host.
//
// Optional feature macro: WEIGHT_REUSE_EN
//   defined   : weights stay loaded across frames; W_LOAD is skipped unless
//               reload_w is high together with start.
//   undefined : every frame loads weights; reload_w is ignored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, reload_w   frame start request (sampled in IDLE), weight reload
//   s_vld, s_data     host byte stream in
//   s_rdy             feeder ready (transfer when s_vld && s_rdy)
//   mode, din, ram_en accelerator load bus (registered, 1-cycle latency)
//   acc_dout,acc_flag accelerator result byte / result valid
//   res_data,res_vld  captured result (held) and its one-cycle update pulse
//   busy              high in every state except IDLE
//   timeout_err       one-cycle pulse when the result wait times out
// ---------------------------------------------------------------------------
module accel_stream_feeder #(
    parameter int N_WEIGHT    = 54,
    parameter int N_DATA      = 64,
    parameter int RES_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       reload_w,
    input  logic       s_vld,
    input  logic [7:0] s_data,
    output logic       s_rdy,
    output logic       mode,
    output logic [7:0] din,
    output logic       ram_en,
    input  logic [7:0] acc_dout,
    input  logic       acc_flag,
    output logic [7:0] res_data,
    output logic       res_vld,
    output logic       busy,
    output logic       timeout_err
);

    localparam int WAIT_W = $clog2(RES_TIMEOUT);
    localparam logic [6:0]        W_LAST = 7'(N_WEIGHT - 1);
    localparam logic [6:0]        D_LAST = 7'(N_DATA - 1);
    localparam logic [WAIT_W-1:0] T_LAST = WAIT_W'(RES_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_W_LOAD = 2'd1,
        ST_D_LOAD = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          byte_cnt_q, byte_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                s_rdy_q, s_rdy_d;
    logic                mode_q, mode_d;
    logic [7:0]          din_q, din_d;
    logic                ram_en_q, ram_en_d;
    logic [7:0]          res_data_q, res_data_d;
    logic                res_vld_q, res_vld_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic                accept_s;

`ifdef WEIGHT_REUSE_EN
    logic                weights_loaded_q, weights_loaded_d;
`else
    // reload_w has no function when weights are always reloaded
    logic                reload_w_unused_s;
    assign reload_w_unused_s = reload_w;
`endif

    // s_rdy is a flop, so an accept is a simple AND with the host valid
    assign accept_s = s_vld && s_rdy_q;

    // Next-state, counters and registered output values
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        res_data_d    = res_data_q;
        res_vld_d     = 1'b0;
        timeout_err_d = 1'b0;
`ifdef WEIGHT_REUSE_EN
        weights_loaded_d = weights_loaded_q;
`endif

        // Load bus: one strobe per accepted byte; mode/din hold while idle
        ram_en_d = accept_s;
        if (accept_s) begin
            din_d  = s_data;
            mode_d = (state_q == ST_W_LOAD);
        end else begin
            din_d  = din_q;
            mode_d = mode_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    byte_cnt_d = 7'd0;
`ifdef WEIGHT_REUSE_EN
                    if (weights_loaded_q && !reload_w) begin
                        state_d = ST_D_LOAD;
                    end else begin
                        state_d = ST_W_LOAD;
                    end
`else
                    state_d = ST_W_LOAD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_W_LOAD: begin
                if (accept_s) begin
                    if (byte_cnt_q == W_LAST) begin
                        state_d    = ST_D_LOAD;
                        byte_cnt_d = 7'd0;
`ifdef WEIGHT_REUSE_EN
                        weights_loaded_d = 1'b1;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 7'd1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            ST_D_LOAD: begin
                if (accept_s) begin
                    if (byte_cnt_q == D_LAST) begin
                        state_d    = ST_WAIT;
                        byte_cnt_d = 7'd0;
                        wait_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 7'd1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle takes priority
                if (acc_flag) begin
                    res_data_d = acc_dout;
                    res_vld_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == T_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    // Stops at T_LAST, so the counter never wraps
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready and busy are decoded from the next state so they are flops
        s_rdy_d = (state_d == ST_W_LOAD) || (state_d == ST_D_LOAD);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= 7'd0;
            wait_cnt_q    <= '0;
            s_rdy_q       <= 1'b0;
            mode_q        <= 1'b0;
            din_q         <= 8'd0;
            ram_en_q      <= 1'b0;
            res_data_q    <= 8'd0;
            res_vld_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            s_rdy_q       <= s_rdy_d;
            mode_q        <= mode_d;
            din_q         <= din_d;
            ram_en_q      <= ram_en_d;
            res_data_q    <= res_data_d;
            res_vld_q     <= res_vld_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef WEIGHT_REUSE_EN
    // Weights-resident flag; reset clears it so the next frame reloads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_loaded_q <= 1'b0;
        end else begin
            weights_loaded_q <= weights_loaded_d;
        end
    end
`endif

    assign s_rdy       = s_rdy_q;
    assign mode        = mode_q;
    assign din         = din_q;
    assign ram_en      = ram_en_q;
    assign res_data    = res_data_q;
    assign res_vld     = res_vld_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_accel_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_accel_stream_feeder
//
// Directed bench for accel_stream_feeder. Every accepted host byte pushes its
// expected load-bus beat (mode, byte, cycle) into a queue; a monitor thread
// pops and compares on each ram_en strobe and checks that mode holds between
// strobes. Honors WEIGHT_REUSE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_accel_stream_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       reload_w;
    logic       s_vld;
    logic [7:0] s_data;
    logic       s_rdy;
    logic       mode;
    logic [7:0] din;
    logic       ram_en;
    logic [7:0] acc_dout;
    logic       acc_flag;
    logic [7:0] res_data;
    logic       res_vld;
    logic       busy;
    logic       timeout_err;

`ifdef WEIGHT_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    typedef struct packed {
        logic        m;
        logic [7:0]  d;
        logic [31:0] c;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int unsigned cyc      = 0;
    int          n_w      = 0;
    int          n_d      = 0;
    logic        last_mode = 1'b0;

    accel_stream_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .reload_w    (reload_w),
        .s_vld       (s_vld),
        .s_data      (s_data),
        .s_rdy       (s_rdy),
        .mode        (mode),
        .din         (din),
        .ram_en      (ram_en),
        .acc_dout    (acc_dout),
        .acc_flag    (acc_flag),
        .res_data    (res_data),
        .res_vld     (res_vld),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 32'({s_rdy, mode, din, ram_en, res_data, res_vld, busy, timeout_err}), 32'd0);
    endtask

    // Compares load-bus strobes against the scoreboard queue
    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                last_mode = 1'b0;
            end else if (ram_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(ram_en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_din", 32'(din), 32'(e.d));
                    chk("strobe_mode", 32'(mode), 32'(e.m));
                    chk("strobe_latency", 32'(cyc), e.c);
                    last_mode = e.m;
                    if (e.m) n_w++; else n_d++;
                end
            end else begin
                chk("mode_hold", 32'(mode), 32'(last_mode));
            end
        end
    endtask

    // Offers one byte and waits (bounded) for it to be accepted
    task automatic send_byte(input logic [7:0] d, input logic m);
        bit got;
        beat_t e;
        got    = 1'b0;
        s_vld  = 1'b1;
        s_data = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_rdy === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_bound", 32'(got), 32'd1);
        if (got) begin
            e.m = m;
            e.d = d;
            e.c = cyc + 32'd1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
        s_vld = 1'b0;
    endtask

    task automatic start_frame(input logic rl);
        n_w      = 0;
        n_d      = 0;
        start    = 1'b1;
        reload_w = rl;
        @(posedge clk);
        #1;
        start    = 1'b0;
        reload_w = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rdy_after_start", 32'(s_rdy), 32'd1);
    endtask

    // Full load of one frame; ends in WAIT just after the last strobe
    task automatic load_frame(input logic rl, input logic exp_w,
                              input logic [7:0] wb, input logic [7:0] db, input bit gaps);
        start_frame(rl);
        if (exp_w) begin
            for (int i = 0; i < 54; i++) begin
                send_byte(8'(wb + 8'(i)), 1'b1);
                if (gaps) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(db + 8'(i)), 1'b0);
        end
        @(negedge clk);
        #1;
        chk("weight_strobes", 32'(n_w), exp_w ? 32'd54 : 32'd0);
        chk("data_strobes", 32'(n_d), 32'd64);
        chk("rdy_in_wait", 32'(s_rdy), 32'd0);
        chk("busy_in_wait", 32'(busy), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        reload_w = 1'b0;
        s_vld    = 1'b0;
        s_data   = 8'd0;
        acc_dout = 8'd0;
        acc_flag = 1'b0;
        fork
            monitor();
            forever begin
                @(posedge clk);
                cyc++;
            end
        join_none

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_rdy", 32'(s_rdy), 32'd0);

        // Frame aborted by reset in the middle of D_LOAD
        start_frame(1'b0);
        for (int i = 0; i < 54; i++) send_byte(8'(8'hA0 + 8'(i)), 1'b1);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + 8'(i)), 1'b0);
        rst_n = 1'b0;
        #1 check_all_zero("midframe_reset_outputs");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full frame 0x00..0x35 / 0x40..0x7F; reset must force a weight load
        load_frame(1'b0, 1'b1, 8'h00, 8'h40, 1'b0);
        // start inside WAIT must be ignored
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("no_res_before_flag", 32'(res_vld), 32'd0);
        acc_dout = 8'h5A;
        acc_flag = 1'b1;
        @(posedge clk);
        #1 acc_flag = 1'b0;
        chk("res_vld_pulse", 32'(res_vld), 32'd1);
        chk("res_data_5a", 32'(res_data), 32'h5A);
        chk("busy_falls", 32'(busy), 32'd0);
        chk("no_timeout_on_result", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        chk("res_vld_one_cycle", 32'(res_vld), 32'd0);
        chk("res_data_held", 32'(res_data), 32'h5A);
        chk("start_in_wait_ignored", 32'(busy), 32'd0);

        // Gapped weight stream, then timeout with no result
        load_frame(1'b1, 1'b1, 8'h80, 8'hC0, 1'b1);
        repeat (255) @(posedge clk);
        #1;
        chk("no_timeout_early", 32'(timeout_err), 32'd0);
        chk("busy_before_timeout", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("timeout_pulse", 32'(timeout_err), 32'd1);
        chk("idle_after_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("timeout_one_cycle", 32'(timeout_err), 32'd0);
        acc_dout = 8'h11;
        acc_flag = 1'b1;
        @(posedge clk);
        #1 acc_flag = 1'b0;
        chk("late_flag_ignored", 32'(res_vld), 32'd0);
        chk("late_flag_data_held", 32'(res_data), 32'h5A);

        // reload_w=0: data only with weight reuse; result on timeout cycle wins
        load_frame(1'b0, !REUSE, 8'h20, 8'h90, 1'b0);
        repeat (255) @(posedge clk);
        #1;
        acc_dout = 8'hC3;
        acc_flag = 1'b1;
        @(posedge clk);
        #1 acc_flag = 1'b0;
        chk("race_res_vld", 32'(res_vld), 32'd1);
        chk("race_res_data", 32'(res_data), 32'hC3);
        chk("race_no_timeout", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1 chk("race_no_late_timeout", 32'(timeout_err), 32'd0);

        // reload_w=1 always reloads weights
        load_frame(1'b1, 1'b1, 8'h33, 8'h07, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        acc_dout = 8'h44;
        acc_flag = 1'b1;
        @(posedge clk);
        #1 acc_flag = 1'b0;
        chk("reload_res_data", 32'(res_data), 32'h44);
        chk("reload_res_vld", 32'(res_vld), 32'd1);

        @(posedge clk);
        #1 chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
